// File: rtl/jt12_eg_kon_sched_if.sv
// Register-side/EG-side bundle for the key-on scheduler.
// The scheduler takes the slave modport; the register file / bench drives the master side.
interface jt12_eg_kon_sched_if;
    logic       clk_en;
    logic       kon_we;
    logic [7:0] din;
    logic       csm_en;
    logic       timer_a_ovf;
    logic       kon_busy;
    logic       kon_ovf;
    logic [4:0] slot_I;
    logic       zero;
    logic       keyon_I;

    modport master (
        output clk_en, kon_we, din, csm_en, timer_a_ovf,
        input  kon_busy, kon_ovf, slot_I, zero, keyon_I
    );

    modport slave (
        input  clk_en, kon_we, din, csm_en, timer_a_ovf,
        output kon_busy, kon_ovf, slot_I, zero, keyon_I
    );
endinterface

// File: rtl/jt12_eg_kon_sched.sv
// Key-on scheduler: 24-slot sequencer, one-entry key-on write buffer committed at frame wrap.
// Optional CSM one-frame key-on of channel code 2 is built when JT12_CSM_EN is defined.
module jt12_eg_kon_sched #(
    parameter int SLOTS = 24
) (
    input logic            clk,
    input logic            rst,
    jt12_eg_kon_sched_if.slave bus
);
    localparam logic [4:0] LAST_SLOT = 5'(SLOTS - 1);

    // Handshake: kon_we is valid and !kon_busy is ready, both qualified by clk_en; a write
    // with valid & ready is accepted on that edge, a write with valid & !ready is dropped.
    typedef enum logic {ST_IDLE = 1'b0, ST_PEND = 1'b1} pend_state_t;

    pend_state_t      state, state_next;
    logic             accept, drop, commit;
    logic [4:0]       slot, slot_next;
    logic             wrap;
    logic [3:0]       pend_ops;
    logic [2:0]       pend_ch;
    logic             ch_valid;
    logic [2:0]       ch_idx;
    logic [SLOTS-1:0] kon, kon_next;
    logic             force_next, force_slot;
    logic             zero_q, keyon_q, ovf_q;
    logic             unused_bits;

    assign unused_bits = bus.din[3];
    assign wrap        = (slot == LAST_SLOT);
    assign slot_next   = wrap ? 5'd0 : slot + 5'd1;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        drop       = 1'b0;
        commit     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.clk_en && bus.kon_we) begin
                    accept     = 1'b1;
                    state_next = ST_PEND;
                end
            end
            ST_PEND: begin
                if (bus.clk_en && bus.kon_we) drop = 1'b1;
                if (bus.clk_en && wrap) begin
                    commit     = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Channel codes 3 and 7 have no slots; they commit as a no-op.
    always_comb begin
        ch_valid = 1'b1;
        ch_idx   = 3'd0;
        case (pend_ch)
            3'd0:    ch_idx = 3'd0;
            3'd1:    ch_idx = 3'd1;
            3'd2:    ch_idx = 3'd2;
            3'd4:    ch_idx = 3'd3;
            3'd5:    ch_idx = 3'd4;
            3'd6:    ch_idx = 3'd5;
            default: ch_valid = 1'b0;
        endcase
    end

    // Slot groups run S1,S3,S2,S4 while the mask bits are S4,S3,S2,S1.
    always_comb begin
        kon_next = kon;
        if (commit && ch_valid) begin
            kon_next[5'd0  + {2'b00, ch_idx}] = pend_ops[0];
            kon_next[5'd6  + {2'b00, ch_idx}] = pend_ops[2];
            kon_next[5'd12 + {2'b00, ch_idx}] = pend_ops[1];
            kon_next[5'd18 + {2'b00, ch_idx}] = pend_ops[3];
        end
    end

    assign force_slot = (slot_next == 5'd2) || (slot_next == 5'd8) ||
                        (slot_next == 5'd14) || (slot_next == 5'd20);

`ifdef JT12_CSM_EN
    logic csm_pend, csm_act, csm_set;

    assign csm_set    = bus.csm_en & bus.timer_a_ovf;
    assign force_next = wrap ? csm_pend : csm_act;

    // The force window opens and closes only on frame wraps, so it spans exactly one frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            csm_pend <= 1'b0;
            csm_act  <= 1'b0;
        end else if (bus.clk_en) begin
            if (wrap) begin
                csm_act  <= csm_pend;
                csm_pend <= csm_set;
            end else if (csm_set) begin
                csm_pend <= 1'b1;
            end
        end
    end
`else
    logic unused_csm;

    assign unused_csm = bus.csm_en ^ bus.timer_a_ovf;
    assign force_next = 1'b0;
`endif

    // keyon_I looks up the post-commit vector so new values show from slot 0 of the new frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot     <= 5'd0;
            zero_q   <= 1'b1;
            keyon_q  <= 1'b0;
            ovf_q    <= 1'b0;
            kon      <= '0;
            pend_ops <= 4'd0;
            pend_ch  <= 3'd0;
        end else begin
            if (bus.clk_en) begin
                slot    <= slot_next;
                zero_q  <= (slot_next == 5'd0);
                kon     <= kon_next;
                keyon_q <= kon_next[slot_next] | (force_next & force_slot);
            end
            if (accept) begin
                pend_ops <= bus.din[7:4];
                pend_ch  <= bus.din[2:0];
            end
            if (drop) ovf_q <= 1'b1;
        end
    end

    assign bus.kon_busy = (state == ST_PEND);
    assign bus.kon_ovf  = ovf_q;
    assign bus.slot_I   = slot;
    assign bus.zero     = zero_q;
    assign bus.keyon_I  = keyon_q;
endmodule
